// File: rtl/nanci_row_drain_if.sv
// Output stream of the Nanci row-drain serializer: one PE word per beat,
// valid/ready handshake, with a marker on the final word of each row.
interface nanci_row_drain_if #(
  parameter int W = 6
);
  logic [W-1:0] o_data;
  logic         o_valid;
  logic         i_ready;
  logic         o_last;

  modport master (
    output o_data,
    output o_valid,
    output o_last,
    input  i_ready
  );

  modport slave (
    input  o_data,
    input  o_valid,
    input  o_last,
    output i_ready
  );
endinterface

// File: rtl/nanci_row_drain.sv
// Snapshots one mesh row of PE words on a capture strobe and drains it as an
// ordered stream; odd rows come out in reverse column order (snake order).
module nanci_row_drain #(
  parameter int COLS       = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 3
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    i_capture,
  input  logic                                    i_row_odd,
  input  logic [COLS*(ADDR_WIDTH+DATA_WIDTH)-1:0] i_PE_row,
  nanci_row_drain_if.master                       strm,
  output logic                                    o_busy,
  output logic                                    o_overrun
);

  localparam int W  = ADDR_WIDTH + DATA_WIDTH;
  localparam int CW = $clog2(COLS);
  localparam logic [CW-1:0] IDX_MAX = CW'(COLS - 1);

  typedef enum logic {
    S_IDLE,
    S_DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          dir_q, dir_d;
  logic [W-1:0]  data_q, data_d;
  logic          last_q, last_d;
  logic          ovr_q, ovr_d;
  logic          snap_ld;
  logic [W-1:0]  row_w  [COLS];
  logic [W-1:0]  snap_q [COLS];

  // Terminal column for a direction: reverse drains end at column 0.
  function automatic logic [CW-1:0] term_idx(input logic dir);
    return dir ? '0 : IDX_MAX;
  endfunction

  // Only called on non-terminal words, so it never wraps past either end.
  function automatic logic [CW-1:0] step_idx(input logic [CW-1:0] idx, input logic dir);
    return dir ? idx - CW'(1) : idx + CW'(1);
  endfunction

  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      row_w[c] = i_PE_row[c*W +: W];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dir_d   = dir_q;
    data_d  = data_q;
    last_d  = last_q;
    ovr_d   = 1'b0;
    snap_ld = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_capture) begin
          snap_ld = 1'b1;
          dir_d   = i_row_odd;
          idx_d   = i_row_odd ? IDX_MAX : '0;
          // First word comes straight from the row so it is valid next cycle.
          data_d  = row_w[idx_d];
          last_d  = 1'b0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // A strobe here is dropped, including on the final beat of the row.
        ovr_d = i_capture;
        if (strm.i_ready) begin
          if (last_q) begin
            state_d = S_IDLE;
            data_d  = '0;
            last_d  = 1'b0;
          end else begin
            idx_d  = step_idx(idx_q, dir_q);
            data_d = snap_q[idx_d];
            last_d = (idx_d == term_idx(dir_q));
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      dir_q   <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
      last_q  <= last_d;
      ovr_q   <= ovr_d;
    end
  end

  // Snapshot storage
  always_ff @(posedge clk) begin
    if (snap_ld) begin
      for (int c = 0; c < COLS; c++) begin
        snap_q[c] <= row_w[c];
      end
    end
  end

  assign strm.o_data  = data_q;
  assign strm.o_valid = (state_q == S_DRAIN);
  assign strm.o_last  = last_q;
  assign o_busy       = (state_q == S_DRAIN);
  assign o_overrun    = ovr_q;

endmodule

// File: tb/tb_nanci_row_drain.sv
// Scoreboard bench for nanci_row_drain: expected words queued at capture,
// popped and compared on every accepted beat.
module tb_nanci_row_drain;
  localparam int COLS = 4;
  localparam int AW   = 3;
  localparam int DW   = 3;
  localparam int W    = AW + DW;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_capture;
  logic            i_row_odd;
  logic [COLS*W-1:0] i_PE_row;
  logic            o_busy;
  logic            o_overrun;

  nanci_row_drain_if #(.W(W)) strm ();

  nanci_row_drain #(
    .COLS      (COLS),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_capture(i_capture),
    .i_row_odd(i_row_odd),
    .i_PE_row (i_PE_row),
    .strm     (strm),
    .o_busy   (o_busy),
    .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  int         nvec = 0;
  int         nerr = 0;
  logic [W:0] exp_q [$];
  logic [W:0] mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_row(input logic [COLS*W-1:0] row, input logic odd);
    i_PE_row  = row;
    i_row_odd = odd;
    i_capture = 1'b1;
    for (int k = 0; k < COLS; k++) begin
      int   c;
      logic lst;
      c   = odd ? (COLS - 1 - k) : k;
      lst = (k == COLS - 1);
      exp_q.push_back({lst, row[c*W +: W]});
    end
    tick();
    i_capture = 1'b0;
    chk("cap_valid", 32'(strm.o_valid), 32'd1);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (strm.o_valid && n < 100) begin
      tick();
      n++;
    end
    chk("drain_bound", 32'(n < 100), 32'd1);
  endtask

  // Accepted-beat monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("busy_eq_valid", 32'(o_busy), 32'(strm.o_valid));
      if (strm.o_valid && strm.i_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("data", 32'(strm.o_data), 32'(mon_e[W-1:0]));
          chk("last", 32'(strm.o_last), 32'(mon_e[W]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [COLS*W-1:0] row_a;
    logic [COLS*W-1:0] row_b;
    logic [31:0]       r;
    int                n;

    row_a = {6'b000100, 6'b000011, 6'b000010, 6'b000001};
    row_b = {6'b001101, 6'b111000, 6'b110000, 6'b101000};

    rst          = 1'b1;
    i_capture    = 1'b0;
    i_row_odd    = 1'b0;
    i_PE_row     = '0;
    strm.i_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_data",    32'(strm.o_data),  32'd0);
    chk("rst_valid",   32'(strm.o_valid), 32'd0);
    chk("rst_last",    32'(strm.o_last),  32'd0);
    chk("rst_busy",    32'(o_busy),       32'd0);
    chk("rst_overrun", 32'(o_overrun),    32'd0);

    // forward drain
    start_row(row_a, 1'b0);
    wait_idle(n);
    chk("fwd_cycles", 32'(n), 32'd4);
    chk("fwd_q", 32'(exp_q.size()), 32'd0);

    // snake reverse
    start_row(row_a, 1'b1);
    wait_idle(n);
    chk("rev_cycles", 32'(n), 32'd4);
    chk("rev_q", 32'(exp_q.size()), 32'd0);

    // backpressure after the first transfer
    start_row(row_a, 1'b0);
    tick();
    strm.i_ready = 1'b0;
    for (int h = 0; h < 3; h++) begin
      chk("bp_hold_data", 32'(strm.o_data), 32'd2);
      chk("bp_hold_last", 32'(strm.o_last), 32'd0);
      tick();
    end
    strm.i_ready = 1'b1;
    wait_idle(n);
    chk("bp_total", 32'(1 + 3 + n), 32'd7);

    // overrun during the second word
    start_row(row_a, 1'b0);
    tick();
    i_PE_row  = row_b;
    i_capture = 1'b1;
    tick();
    i_capture = 1'b0;
    chk("ovr_pulse", 32'(o_overrun), 32'd1);
    tick();
    chk("ovr_one_cycle", 32'(o_overrun), 32'd0);
    wait_idle(n);
    chk("ovr_tail", 32'(n), 32'd1);
    chk("ovr_q", 32'(exp_q.size()), 32'd0);

    // reset mid-drain, then a fresh row
    start_row(row_a, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_valid", 32'(strm.o_valid), 32'd0);
    chk("mrst_data",  32'(strm.o_data),  32'd0);
    chk("mrst_busy",  32'(o_busy),       32'd0);
    chk("mrst_last",  32'(strm.o_last),  32'd0);
    exp_q.delete();
    start_row(row_b, 1'b0);
    wait_idle(n);
    chk("mrst_cycles", 32'(n), 32'd4);

    // capture in the same cycle as the last transfer
    start_row(row_a, 1'b0);
    repeat (3) tick();
    chk("col_last_shown", 32'(strm.o_last), 32'd1);
    i_PE_row  = row_b;
    i_row_odd = 1'b1;
    i_capture = 1'b1;
    tick();
    i_capture = 1'b0;
    chk("col_overrun", 32'(o_overrun),    32'd1);
    chk("col_idle",    32'(strm.o_valid), 32'd0);
    tick();
    chk("col_no_drain",   32'(strm.o_valid), 32'd0);
    chk("col_ovr_clear",  32'(o_overrun),    32'd0);

    // random rows under random backpressure
    for (int t = 0; t < 8; t++) begin
      r = $urandom;
      start_row(r[COLS*W-1:0], 1'($urandom_range(0, 1)));
      n = 0;
      while (strm.o_valid && n < 200) begin
        strm.i_ready = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
      strm.i_ready = 1'b1;
      chk("rnd_done", 32'(strm.o_valid), 32'd0);
    end

    chk("final_q", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/nanci_row_drain.md
# nanci_row_drain

Row-drain serializer that sits directly downstream of one row of PE instances in the Nanci mesh. On a capture strobe it snapshots the `o_PE` word of every PE in the row in parallel, then emits the words one per cycle over a valid/ready stream. It emits odd rows in reverse column order, so a sorted mesh comes out in snake (boustrophedon) order. Downstream consumers (result checker, output FIFO) see a single ordered stream per row.

## Interface
Parameters:
- COLS, 4, number of PEs in the row (≥2)
- ADDR_WIDTH, 3, address field width of a PE word
- DATA_WIDTH, 3, data field width of a PE word
- W (derived, not overridable), ADDR_WIDTH+DATA_WIDTH, PE word width
- CW (derived), ceil(log2(COLS)), column index width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_capture  in  1  one-cycle strobe: snapshot the row
- i_row_odd  in  1  sampled with i_capture; 1 = emit in reverse column order
- i_PE_row  in  COLS*W  concatenated PE outputs; column c occupies bits [c*W +: W]
- o_data  out  W  current output word
- o_valid  out  1  o_data valid
- i_ready  in  1  consumer accepts o_data this cycle
- o_last  out  1  high with the final word of a row
- o_busy  out  1  drain in progress (state DRAIN)
- o_overrun  out  1  one-cycle pulse: i_capture arrived while busy and was dropped

## Operation
- State machine with two states, IDLE and DRAIN. Reset enters IDLE.
- IDLE with i_capture=1:
  - copy i_PE_row into the COLS×W snapshot register;
  - latch i_row_odd into dir;
  - load the index counter with 0 if dir=0, or COLS-1 if dir=1;
  - go to DRAIN.
- DRAIN:
  - o_valid=1; o_data=snapshot[idx]; o_last=1 when idx is the terminal index (COLS-1 for dir=0, 0 for dir=1).
  - Transfer occurs when o_valid & i_ready.
  - On a transfer that is not last: idx increments (dir=0) or decrements (dir=1).
  - On the last transfer: go to IDLE, clear o_valid.
- Backpressure: if i_ready=0, o_data, o_last and idx hold unchanged.
- i_capture during DRAIN: ignored, snapshot untouched, o_overrun pulses high for exactly one cycle (registered, the cycle after the strobe).
- i_capture in the same cycle as the last transfer: still counts as DRAIN, so it is dropped with o_overrun. A new capture is accepted only when the state is IDLE.
- The index never wraps. The terminal index always ends the drain. COLS that is not a power of 2 must work; idx never exceeds COLS-1.
- The snapshot is raw: no field interpretation, and address and data bits pass through unchanged.
- rst asserted mid-drain: next cycle is IDLE, all outputs zero, and the remaining words are discarded.

## Timing
- Reset values: o_data=0, o_valid=0, o_last=0, o_busy=0, o_overrun=0; state IDLE; idx=0; dir=0.
- All outputs are registered; there is no combinational path from i_ready or i_capture to any output.
- Capture latency: i_capture sampled at edge k → o_valid=1 and first word on o_data after edge k; a consumer with i_ready held high takes it at edge k+1.
- Throughput: one word per cycle with i_ready held high; a row drains in COLS cycles. Earliest next capture is the cycle after the last transfer, so minimum row period is COLS+1 cycles.
- o_busy equals o_valid in every cycle.

## Test plan
- Forward drain: COLS=4, W=6. i_PE_row words c0..c3 = 000001, 000010, 000011, 000100; i_row_odd=0; i_ready=1 → o_data 000001, 000010, 000011, 000100 on 4 consecutive cycles, o_last only on 000100, o_valid low on the next cycle.
- Snake reverse: same row with i_row_odd=1 → o_data 000100, 000011, 000010, 000001; o_last on 000001.
- Backpressure: forward drain with i_ready low for 3 cycles after the first transfer → o_data holds 000010 for 3 cycles; the order is otherwise unchanged and total drain time is 7 cycles.
- Overrun: i_capture pulsed during the second word of a drain with a different row value → o_overrun=1 for one cycle; the remaining words come from the original snapshot; o_busy drops after the original 4th word.
- Reset mid-drain: rst=1 after 2 transfers → next cycle o_valid=0, o_data=0, o_busy=0. A fresh capture of 101000, 110000, 111000, 001101 then drains from column 0 correctly.
- Capture/last collision: i_capture asserted in the same cycle as the o_last transfer → o_overrun pulses, state returns to IDLE, no new drain starts.
